// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/DIV unit with HI/LO registers, sequenced from the E stage.
// Define MDU_MADD_EN to enable the MADD/MADDU accumulate ops (6/7); otherwise they are no-ops.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MADDU = 3'd7
  } op_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic        r_busy, w_busy_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;
  logic [63:0] r_pend, w_pend_nxt;

  op_t         w_op;
  logic [63:0] w_prod_s, w_prod_u, w_result;
  logic [31:0] w_quo_s, w_rem_s, w_quo_u, w_rem_u;
  logic        w_div_zero, w_div_ovf, w_is_arith, w_is_div;
  logic [4:0]  w_cycles;

  assign w_op = op_t'(op);

  // The whole result is formed from the operands present at the start edge.
  assign w_prod_s = $signed({{32{operandA[31]}}, operandA}) *
                    $signed({{32{operandB[31]}}, operandB});
  assign w_prod_u = {32'd0, operandA} * {32'd0, operandB};

  assign w_quo_s = $signed(operandA) / $signed(operandB);
  assign w_rem_s = $signed(operandA) % $signed(operandB);
  assign w_quo_u = operandA / operandB;
  assign w_rem_u = operandA % operandB;

  assign w_div_zero = (operandB == 32'd0);
  assign w_div_ovf  = (operandA == 32'h8000_0000) && (operandB == 32'hFFFF_FFFF);

  assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
`ifdef MDU_MADD_EN
  assign w_is_arith = (op <= 3'd3) || (w_op == OP_MADD) || (w_op == OP_MADDU);
`else
  assign w_is_arith = (op <= 3'd3);
`endif
  assign w_cycles = w_is_div ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);

  // NOTE: every signal driven in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_result = 64'd0;
    case (w_op)
      OP_MULT:  w_result = w_prod_s;
      OP_MULTU: w_result = w_prod_u;
      OP_DIV: begin
        if (w_div_zero)     w_result = {operandA, 32'hFFFF_FFFF};
        else if (w_div_ovf) w_result = {32'd0, 32'h8000_0000};
        else                w_result = {w_rem_s, w_quo_s};
      end
      OP_DIVU: begin
        if (w_div_zero) w_result = {operandA, 32'hFFFF_FFFF};
        else            w_result = {w_rem_u, w_quo_u};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  w_result = {r_hi, r_lo} + w_prod_s;
      OP_MADDU: w_result = {r_hi, r_lo} + w_prod_u;
`endif
      default:  w_result = 64'd0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_pend_nxt  = r_pend;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) begin
          if (w_is_arith) begin
            w_pend_nxt  = w_result;
            w_cnt_nxt   = w_cycles;
            w_busy_nxt  = 1'b1;
            w_state_nxt = S_RUN;
          end else if (w_op == OP_MTHI) begin
            w_hi_nxt = operandA;
          end else if (w_op == OP_MTLO) begin
            w_lo_nxt = operandA;
          end
        end
      end
      S_RUN: begin
        // A flush drops the pending result; start is ignored while running.
        if (flush) begin
          w_cnt_nxt   = 5'd0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 5'd1) begin
          w_hi_nxt    = r_pend[63:32];
          w_lo_nxt    = r_pend[31:0];
          w_cnt_nxt   = 5'd0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 5'd1;
        end
      end
      default: begin
        w_cnt_nxt   = 5'd0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_busy  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_pend  <= 64'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, arithmetic corner cases, flush and async reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] operandA = 32'd0;
  logic [31:0] operandB = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_compared   = 0;
  int n_mismatched = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .operandA (operandA),
    .operandB (operandB),
    .flush    (flush),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one op, scramble the operands afterwards, count busy cycles, check hi/lo.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; operandA = a; operandB = b;
    @(negedge clk);
    start = 1'b0; operandA = ~a; operandB = ~b;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({tag, ".cycles"}, 32'(n), 32'(exp_n));
    check({tag, ".hi"}, hi, exp_hi);
    check({tag, ".lo"}, lo, exp_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.hi", hi, 32'd0);
    check("reset.lo", lo, 32'd0);
    reset_n = 1'b1;

    run_op("mult_neg",   3'd0, 32'hFFFF_FFFF, 32'd2,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu",      3'd1, 32'hFFFF_FFFF, 32'd2,         5,  32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_m3x5",  3'd0, 32'hFFFF_FFFD, 32'd5,         5,  32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div_m7",     3'd2, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_7",     3'd3, 32'd7,         32'd2,         10, 32'd1,         32'd3);
    run_op("div_zero",   3'd2, 32'd5,         32'd0,         10, 32'd5,         32'hFFFF_FFFF);
    run_op("div_ovf",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000);
    run_op("div_100_m7", 3'd2, 32'd100,       32'hFFFF_FFF9, 10, 32'd2,         32'hFFFF_FFF2);
    run_op("divu_zero",  3'd3, 32'h1234_5678, 32'd0,         10, 32'h1234_5678, 32'hFFFF_FFFF);
    run_op("mthi",       3'd4, 32'h1111_1111, 32'd0,         0,  32'h1111_1111, 32'hFFFF_FFFF);
    run_op("mtlo",       3'd5, 32'h2222_2222, 32'd0,         0,  32'h1111_1111, 32'h2222_2222);

    // Flush on the third busy cycle of DIV 9/3: result must never land.
    @(negedge clk);
    start = 1'b1; op = 3'd2; operandA = 32'd9; operandB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("flush.busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush.busy_after", 32'(busy), 32'd0);
    check("flush.hi", hi, 32'h1111_1111);
    check("flush.lo", lo, 32'h2222_2222);
    repeat (12) @(negedge clk);
    check("flush.busy_late", 32'(busy), 32'd0);
    check("flush.lo_late", lo, 32'h2222_2222);

    // Flush together with start in IDLE: start is dropped.
    start = 1'b1; flush = 1'b1; op = 3'd0; operandA = 32'd3; operandB = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start.busy", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    check("flush_start.hi", hi, 32'h1111_1111);
    check("flush_start.lo", lo, 32'h2222_2222);

    // Flush alone in IDLE changes nothing.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle.busy", 32'(busy), 32'd0);
    check("flush_idle.hi", hi, 32'h1111_1111);

    // DIVU 7/2 with a MULT start raised mid-run: latency and result unaffected.
    start = 1'b1; op = 3'd3; operandA = 32'd7; operandB = 32'd2;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      start = (n == 2);
      if (n == 2) begin
        op = 3'd0; operandA = 32'd3; operandB = 32'd3;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("midrun.cycles", 32'(n), 32'd10);
    check("midrun.hi", hi, 32'd1);
    check("midrun.lo", lo, 32'd3);
    repeat (8) @(negedge clk);
    check("midrun.busy_late", 32'(busy), 32'd0);
    check("midrun.lo_late", lo, 32'd3);

`ifdef MDU_MADD_EN
    run_op("madd.mthi",  3'd4, 32'd0,         32'd0, 0, 32'd0, 32'd3);
    run_op("madd.mtlo",  3'd5, 32'hFFFF_FFFF, 32'd0, 0, 32'd0, 32'hFFFF_FFFF);
    run_op("maddu_1x1",  3'd7, 32'd1,         32'd1, 5, 32'd1, 32'd0);
    run_op("madd_m1x1",  3'd6, 32'hFFFF_FFFF, 32'd1, 5, 32'd0, 32'hFFFF_FFFF);
`else
    run_op("madd_off",   3'd6, 32'd5, 32'd5, 0, 32'd1, 32'd3);
    run_op("maddu_off",  3'd7, 32'd5, 32'd5, 0, 32'd1, 32'd3);
`endif

    // Async reset during the second busy cycle of a MULT.
    run_op("pre_rst.mthi", 3'd4, 32'hABCD_0123, 32'd0, 0, 32'hABCD_0123, lo);
    @(negedge clk);
    start = 1'b1; op = 3'd0; operandA = 32'd6; operandB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rst.busy_before", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.hi", hi, 32'd0);
    check("rst.lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("rst.busy_late", 32'(busy), 32'd0);
    check("rst.lo_late", lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
